// File: rtl/mul_seq.sv
// Sequential 32x32 -> 64 shift-add multiplier with signed/unsigned operands (IDLE/CALC/DONE).
// Define MUL_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module mul_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mult_begin,
  input  logic [31:0] mult_op1,
  input  logic [31:0] mult_op2,
  input  logic        mult_signed,
  output logic        busy,
  output logic        mult_end,
  output logic [63:0] product
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [63:0] work;
  logic [5:0]  count;
  logic        sign;

  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] sum;
  logic [63:0] shifted;

  // Magnitudes are taken as unsigned, so -2^31 maps cleanly to 0x80000000.
  assign mag1 = (mult_signed && mult_op1[31]) ? (~mult_op1 + 32'd1) : mult_op1;
  assign mag2 = (mult_signed && mult_op2[31]) ? (~mult_op2 + 32'd1) : mult_op2;

  assign sum     = {1'b0, work[63:32]} + {1'b0, (work[0] ? mcand : 32'h0)};
  assign shifted = {sum, work[31:1]};
  assign busy    = (state != IDLE);

`ifdef MUL_SEQ_EARLY_EXIT_EN
  logic [30:0] rest_mask;
  logic        early;
  logic [63:0] exit_work;

  // Unconsumed multiplier bits sit in work[31-count:1]; once they are zero only shifts remain.
  assign rest_mask = 31'h7FFF_FFFF >> count[4:0];
  assign early     = ((work[31:1] & rest_mask) == 31'h0);
  assign exit_work = shifted >> (5'd31 - count[4:0]);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      mcand    <= 32'h0;
      work     <= 64'h0;
      count    <= 6'd0;
      sign     <= 1'b0;
      product  <= 64'h0;
      mult_end <= 1'b0;
    end else begin
      mult_end <= 1'b0;
      case (state)
        IDLE: begin
          if (mult_begin) begin
            mcand <= mag1;
            work  <= {32'h0, mag2};
            sign  <= mult_signed & (mult_op1[31] ^ mult_op2[31]);
            count <= 6'd0;
            state <= CALC;
          end
        end
        CALC: begin
          count <= count + 6'd1;
`ifdef MUL_SEQ_EARLY_EXIT_EN
          if (early) begin
            work  <= exit_work;
            state <= DONE;
          end else begin
            work <= shifted;
            if (count == 6'd31) state <= DONE;
          end
`else
          work <= shifted;
          if (count == 6'd31) state <= DONE;
`endif
        end
        DONE: begin
          product  <= sign ? (~work + 64'd1) : work;
          mult_end <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: vector table plus hand-written sequences for re-pulse, back-to-back and mid-run reset.
// Latency expectations follow MUL_SEQ_EARLY_EXIT_EN when it is defined.
module tb_mul_seq;

  logic        clk;
  logic        resetn;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic        mult_signed;
  logic        busy;
  logic        mult_end;
  logic [63:0] product;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sgn;
    logic [63:0] exp_product;
  } vec_t;

  vec_t vecs[10];

  mul_seq dut (
    .clk        (clk),
    .resetn     (resetn),
    .mult_begin (mult_begin),
    .mult_op1   (mult_op1),
    .mult_op2   (mult_op2),
    .mult_signed(mult_signed),
    .busy       (busy),
    .mult_end   (mult_end),
    .product    (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  // Expected edges from begin to mult_end, from the magnitude of the multiplier.
  function automatic int exp_latency(input logic [31:0] op2, input logic sgn);
    logic [31:0] m;
    int k;
    m = (sgn && op2[31]) ? (~op2 + 32'd1) : op2;
    k = -1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    return (k < 0) ? 2 : k + 2;
`else
    return 33;
`endif
  endfunction

  // Called just after a falling edge; returns just after the falling edge following edge 0.
  task automatic apply_stimulus(input logic [31:0] op1, input logic [31:0] op2, input logic sgn);
    mult_op1    = op1;
    mult_op2    = op2;
    mult_signed = sgn;
    mult_begin  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mult_begin = 1'b0;
  endtask

  task automatic wait_end(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (mult_end) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    resetn      = 1'b1;
    mult_begin  = 1'b0;
    mult_op1    = 32'h0;
    mult_op2    = 32'h0;
    mult_signed = 1'b0;

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'hFFFF_FFFD, 32'h0000_0000, 1'b1, 64'h0000_0000_0000_0000};
    vecs[4] = '{32'h1234_5678, 32'h0000_0001, 1'b0, 64'h0000_0000_1234_5678};
    vecs[5] = '{32'h0000_0003, 32'h0001_0000, 1'b0, 64'h0000_0000_0003_0000};
    vecs[6] = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA};
    vecs[7] = '{32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000};
    vecs[8] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
    vecs[9] = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 64'h0000_0002_FFFF_FFFA};

    #3 resetn = 1'b0;
    #1;
    check_output("reset_busy", {63'h0, busy}, 64'h0);
    check_output("reset_mult_end", {63'h0, mult_end}, 64'h0);
    check_output("reset_product", product, 64'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Table-driven vectors, each checking busy, latency, product and single-cycle pulse.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].op1, vecs[i].op2, vecs[i].sgn);
      check_output($sformatf("vec%0d_busy", i), {63'h0, busy}, 64'h1);
      wait_end(lat);
      check_output($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_latency(vecs[i].op2, vecs[i].sgn)));
      check_output($sformatf("vec%0d_product", i), product, vecs[i].exp_product);
      @(negedge clk);
      check_output($sformatf("vec%0d_end_low", i), {62'h0, mult_end, busy}, 64'h0);
    end

    // Re-pulse of begin at edge 10 with other operands must be ignored.
    apply_stimulus(32'h0000_0003, 32'h8000_0001, 1'b0);
    for (int n = 1; n <= 9; n++) @(negedge clk);
    mult_op1   = 32'h0000_0064;
    mult_op2   = 32'h0000_0064;
    mult_begin = 1'b1;
    @(negedge clk);
    mult_begin = 1'b0;
    wait_end(lat);
    check_output("repulse_latency", 64'(lat + 10), 64'd33);
    check_output("repulse_product", product, 64'h0000_0001_8000_0003);

    // Begin in the mult_end cycle is accepted; product stays held until the next DONE.
    apply_stimulus(32'h0000_0002, 32'h0000_0005, 1'b0);
    check_output("b2b_busy", {63'h0, busy}, 64'h1);
    check_output("b2b_mult_end", {63'h0, mult_end}, 64'h0);
    check_output("b2b_product_held", product, 64'h0000_0001_8000_0003);
    wait_end(lat);
    check_output("b2b_latency", 64'(lat), 64'(exp_latency(32'h0000_0005, 1'b0)));
    check_output("b2b_product", product, 64'h0000_0000_0000_000A);
    @(negedge clk);

    // Reset asserted mid-run discards the operation immediately.
    apply_stimulus(32'h0000_0007, 32'h8000_0000, 1'b0);
    for (int n = 1; n <= 14; n++) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_output("midreset_busy", {63'h0, busy}, 64'h0);
    check_output("midreset_product", product, 64'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mult_end || busy) pulses++;
    end
    check_output("midreset_quiet", 64'(pulses), 64'h0);
    apply_stimulus(32'h0000_0009, 32'h0000_0009, 1'b1);
    wait_end(lat);
    check_output("post_reset_latency", 64'(lat), 64'(exp_latency(32'h0000_0009, 1'b1)));
    check_output("post_reset_product", product, 64'h0000_0000_0000_0051);

    // Start accepted at the very first edge after reset release.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check_output("first_edge_busy", {63'h0, busy}, 64'h1);
    wait_end(lat);
    check_output("first_edge_product", product, 64'h0000_0000_0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and product width at 64 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 mult_begin  input  1  start request; sampled only in IDLE.
REQ-005 mult_op1  input  32  multiplicand; sampled with an accepted mult_begin.
REQ-006 mult_op2  input  32  multiplier; sampled with an accepted mult_begin.
REQ-007 mult_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with an accepted mult_begin.
REQ-008 busy  output  1  high in CALC and DONE states.
REQ-009 mult_end  output  1  one-cycle pulse; product is valid in that cycle.
REQ-010 product  output  64  result; held from mult_end until the next accepted start.

Function
REQ-011 States SHALL be IDLE, CALC and DONE; the state register resets to IDLE.
REQ-012 Start acceptance: IDLE with mult_begin=1 at an edge -> latch |op1| (mcand), |op2| (low half of 64-bit work register), result sign = mult_signed & (op1[31]^op2[31]); clear the high half and iteration count; go to CALC.
REQ-013 mult_begin in CALC or DONE SHALL be ignored, with no queuing.
REQ-014 Each CALC edge: {cout,sum} = hi + (lo[0] ? mcand : 0) using one shared 32-bit adder with cin=0; work <= {cout,sum,lo[31:1]}; count += 1.
REQ-015 CALC -> DONE after the iteration in which count reaches 32.
REQ-016 DONE edge: product <= sign ? (~work + 1) : work, as a 64-bit two's complement; mult_end <= 1; go to IDLE.
REQ-017 mult_end SHALL be registered, high for exactly the cycle after the DONE edge, and 0 otherwise.
REQ-018 Baseline latency: begin sampled at edge 0 -> iterations at edges 1..32 -> mult_end high after edge 33.
REQ-019 Magnitude of 0x80000000 in signed mode SHALL be 0x80000000, treated as unsigned, with no overflow.
REQ-020 A zero result SHALL remain zero after sign correction.
REQ-021 mult_begin high in the mult_end cycle (state IDLE) SHALL be accepted.
REQ-022 product SHALL change only on the DONE edge or on reset.

Reset
REQ-023 resetn low SHALL immediately force state=IDLE, busy=0, mult_end=0, product=0, work=0, count=0, from any state including mid-CALC; the operation in progress is discarded.
REQ-024 The first start SHALL be accepted at the first edge with resetn high.

Configuration
REQ-025 Macro MUL_SEQ_EARLY_EXIT_EN defined: a CALC edge whose unconsumed multiplier bits above the current bit are all zero SHALL perform its iteration plus the remaining right shift (32-count-1 positions) and go to DONE.
REQ-026 With MUL_SEQ_EARLY_EXIT_EN defined, latency SHALL be k+2 edges to mult_end, where k is the index of the MSB of |op2|; it SHALL be 2 when |op2|=0.
REQ-027 Macro MUL_SEQ_EARLY_EXIT_EN undefined: always 32 iterations and latency 33 edges; the product SHALL be identical in both builds.

Verification
REQ-028 Unsigned op1=0xFFFFFFFF, op2=0xFFFFFFFF -> product=0xFFFFFFFE00000001, mult_end 33 edges after begin (no macro).
REQ-029 Signed op1=0xFFFFFFFF (-1), op2=0x00000005 -> product=0xFFFFFFFFFFFFFFFB; signed op1=op2=0x80000000 -> product=0x4000000000000000.
REQ-030 Signed op1=0xFFFFFFFD, op2=0 -> product=0; with macro, mult_end 2 edges after begin.
REQ-031 begin re-pulsed at edge 10 of a run with different operands -> ignored, first result unchanged; begin in the mult_end cycle -> accepted, busy high next cycle.
REQ-032 resetn low at edge 15 of a run -> busy=0, product=0 immediately; no mult_end; the next begin completes normally.
REQ-033 With macro, op2=0x00000001, op1=0x12345678 -> product=0x0000000012345678, mult_end 2 edges after begin; op2=0x00010000 -> mult_end 18 edges after begin.
